// File: rtl/leaf_user_pkg.sv
// leaf_user_pkg: payload width, payload type and frame defaults shared by the user-side leaf kernels
package leaf_user_pkg;
    localparam int PAYLOAD_BITS = 32;
    localparam int FRAME_LEN_DEFAULT = 64;
    localparam int CNT_BITS_DEFAULT = 16;
    typedef logic [PAYLOAD_BITS-1:0] payload_t;
endpackage

// File: rtl/leaf_fifo2.sv
// leaf_fifo2: 2-entry synchronous FIFO with registered not_full, push/pop and occupancy count
module leaf_fifo2 #(
    parameter int W = leaf_user_pkg::PAYLOAD_BITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count,
    output logic         not_full
);
    logic [W-1:0] mem [2];
    logic         wr, rd;
    logic [1:0]   count_nxt;
    assign count_nxt = count + {1'b0, push} - {1'b0, pop};
    assign dout = mem[rd];
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            wr       <= 1'b0;
            rd       <= 1'b0;
            not_full <= 1'b0;
        end else begin
            count    <= count_nxt;
            not_full <= count_nxt != 2'd2;
            wr       <= wr ^ push;
            rd       <= rd ^ pop;
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wr] <= din;
endmodule

// File: rtl/leaf_i2o1_pair_adder.sv
// leaf_i2o1_pair_adder: joins two streams beat-by-beat into their sum with frame counting; PAIR_ADDER_SAT_EN selects saturating add
module leaf_i2o1_pair_adder #(
    parameter int PAYLOAD_BITS = leaf_user_pkg::PAYLOAD_BITS,
    parameter int FRAME_LEN    = leaf_user_pkg::FRAME_LEN_DEFAULT,
    parameter int CNT_BITS     = leaf_user_pkg::CNT_BITS_DEFAULT
) (
    input  logic                    clk_user,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user_1,
    input  logic                    vld_interface2user_1,
    output logic                    ack_user2interface_1,
    input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user_2,
    input  logic                    vld_interface2user_2,
    output logic                    ack_user2interface_2,
    output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_1,
    output logic                    vld_user2interface_1,
    input  logic                    ack_interface2user_1,
    output logic                    frame_done,
    output logic [CNT_BITS-1:0]     beat_cnt
);
    logic [PAYLOAD_BITS-1:0] a, b, sum;
    logic [1:0]              count_1, count_2;
    logic                    push_1, push_2, fire, xfer, last;
    assign push_1 = vld_interface2user_1 && ack_user2interface_1;
    assign push_2 = vld_interface2user_2 && ack_user2interface_2;
    assign xfer   = vld_user2interface_1 && ack_interface2user_1;
    assign fire   = count_1 != 2'd0 && count_2 != 2'd0 && (!vld_user2interface_1 || ack_interface2user_1);
    assign last   = beat_cnt == CNT_BITS'(FRAME_LEN - 1);
    leaf_fifo2 #(.W(PAYLOAD_BITS)) fifo_1 (
        .clk(clk_user), .rst(reset), .push(push_1), .pop(fire),
        .din(dout_leaf_interface2user_1), .dout(a), .count(count_1), .not_full(ack_user2interface_1)
    );
    leaf_fifo2 #(.W(PAYLOAD_BITS)) fifo_2 (
        .clk(clk_user), .rst(reset), .push(push_2), .pop(fire),
        .din(dout_leaf_interface2user_2), .dout(b), .count(count_2), .not_full(ack_user2interface_2)
    );
`ifdef PAIR_ADDER_SAT_EN
    logic [PAYLOAD_BITS:0] wide;
    assign wide = {1'b0, a} + {1'b0, b};
    assign sum  = wide[PAYLOAD_BITS] ? '1 : wide[PAYLOAD_BITS-1:0];
`else
    assign sum = a + b;
`endif
    always_ff @(posedge clk_user) begin
        if (reset) begin
            din_leaf_user2interface_1 <= '0;
            vld_user2interface_1      <= 1'b0;
            frame_done                <= 1'b0;
            beat_cnt                  <= '0;
        end else begin
            if (fire) begin
                din_leaf_user2interface_1 <= sum;
                vld_user2interface_1      <= 1'b1;
            end else if (ack_interface2user_1) begin
                vld_user2interface_1      <= 1'b0;
            end
            frame_done <= xfer && last;
            if (xfer) beat_cnt <= last ? '0 : beat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_leaf_i2o1_pair_adder.sv
// tb_leaf_i2o1_pair_adder: directed table and sequence checks of the pair adder with FRAME_LEN=4
module tb_leaf_i2o1_pair_adder;
    logic        clk = 1'b0, reset = 1'b1;
    logic [31:0] d1 = '0, d2 = '0, dout;
    logic        v1 = 1'b0, v2 = 1'b0, a1, a2, vo, ao = 1'b1, fd;
    logic [15:0] bc;
    int          n_vec = 0, n_bad = 0;
    logic [31:0] got[$];
    int          pulses[$];
    bit          hold_en = 1'b0, prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    typedef struct { logic [31:0] a, b, s; } vec_t;
    vec_t tv[6];
`ifdef PAIR_ADDER_SAT_EN
    localparam logic [31:0] OVF_A = 32'hFFFF_FFFF, OVF_B = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] OVF_A = 32'h0000_0001, OVF_B = 32'h0000_0000;
`endif
    always #5 clk = ~clk;
    leaf_i2o1_pair_adder #(.FRAME_LEN(4)) dut (
        .clk_user(clk), .reset(reset),
        .dout_leaf_interface2user_1(d1), .vld_interface2user_1(v1), .ack_user2interface_1(a1),
        .dout_leaf_interface2user_2(d2), .vld_interface2user_2(v2), .ack_user2interface_2(a2),
        .din_leaf_user2interface_1(dout), .vld_user2interface_1(vo), .ack_interface2user_1(ao),
        .frame_done(fd), .beat_cnt(bc)
    );
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask
    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        if (!reset) begin
            if (hold_en && prev_stall) begin
                chk("hold_vld", {31'd0, vo}, 32'd1);
                chk("hold_data", dout, prev_d);
            end
            if (fd) pulses.push_back(got.size());
            if (vo && ao) got.push_back(dout);
            prev_stall = vo && !ao;
            prev_d = dout;
        end else prev_stall = 1'b0;
    end
    task automatic send1(logic [31:0] v);
        int t = 0;
        d1 = v;
        v1 = 1'b1;
        while (!a1 && t < 200) begin tick(); t++; end
        chk("send1_ack", {31'd0, a1}, 32'd1);
        tick();
        v1 = 1'b0;
    endtask
    task automatic send2(logic [31:0] v);
        int t = 0;
        d2 = v;
        v2 = 1'b1;
        while (!a2 && t < 200) begin tick(); t++; end
        chk("send2_ack", {31'd0, a2}, 32'd1);
        tick();
        v2 = 1'b0;
    endtask
    task automatic wait_got(int n);
        int t = 0;
        while (got.size() < n && t < 500) begin tick(); t++; end
        chk("out_count", got.size(), n);
    endtask
    task automatic do_reset();
        reset = 1'b1;
        v1 = 1'b0;
        v2 = 1'b0;
        ao = 1'b1;
        tick(2);
        reset = 1'b0;
        got.delete();
        pulses.delete();
        tick();
    endtask
    function automatic logic [31:0] at(int i);
        return got.size() > i ? got[i] : 32'hDEAD_BEEF;
    endfunction
    initial begin
        tv[0] = '{32'd100, 32'd23, 32'd123};
        tv[1] = '{32'hFFFF_FFFF, 32'd2, OVF_A};
        tv[2] = '{32'h8000_0000, 32'h8000_0000, OVF_B};
        tv[3] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789};
        tv[4] = '{32'h7FFF_FFFF, 32'd1, 32'h8000_0000};
        tv[5] = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
        tick(2);
        chk("rst_ack1", {31'd0, a1}, 32'd0);
        chk("rst_ack2", {31'd0, a2}, 32'd0);
        chk("rst_vld", {31'd0, vo}, 32'd0);
        chk("rst_data", dout, 32'd0);
        chk("rst_frame_done", {31'd0, fd}, 32'd0);
        chk("rst_beat_cnt", {16'd0, bc}, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_ack1", {31'd0, a1}, 32'd1);
        chk("post_rst_ack2", {31'd0, a2}, 32'd1);
        d1 = 32'd5; d2 = 32'd7; v1 = 1'b1; v2 = 1'b1;
        tick();
        v1 = 1'b0; v2 = 1'b0;
        chk("latency_idle", {31'd0, vo}, 32'd0);
        tick();
        chk("first_vld", {31'd0, vo}, 32'd1);
        chk("first_sum", dout, 32'd12);
        tick();
        chk("vld_one_cycle", {31'd0, vo}, 32'd0);
        chk("first_beat_cnt", {16'd0, bc}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            got.delete();
            fork
                send1(tv[i].a);
                send2(tv[i].b);
            join
            wait_got(1);
            chk($sformatf("table_sum_%0d", i), at(0), tv[i].s);
        end
        do_reset();
        send1(32'd1);
        send1(32'd2);
        d1 = 32'd3;
        v1 = 1'b1;
        tick(4);
        chk("one_side_ack1_low", {31'd0, a1}, 32'd0);
        chk("one_side_no_out", got.size(), 32'd0);
        fork
            send1(32'd3);
            begin send2(32'd10); send2(32'd20); send2(32'd30); end
        join
        wait_got(3);
        chk("order_0", at(0), 32'd11);
        chk("order_1", at(1), 32'd22);
        chk("order_2", at(2), 32'd33);
        do_reset();
        hold_en = 1'b1;
        fork
            for (int i = 1; i <= 100; i++) send1(i);
            for (int i = 1; i <= 100; i++) send2(i);
            begin
                int t = 0;
                while (got.size() < 100 && t < 2000) begin ao = !ao; tick(); t++; end
            end
        join
        ao = 1'b1;
        hold_en = 1'b0;
        tick(3);
        chk("stream_count", got.size(), 32'd100);
        for (int i = 0; i < 100; i++) chk($sformatf("stream_%0d", i), at(i), 2 * (i + 1));
        do_reset();
        fork
            for (int i = 1; i <= 9; i++) send1(i);
            for (int i = 1; i <= 9; i++) send2(i);
        join
        wait_got(9);
        tick(2);
        chk("frame_pulses", pulses.size(), 32'd2);
        chk("frame_pulse_0", pulses.size() > 0 ? pulses[0] : -1, 32'd4);
        chk("frame_pulse_1", pulses.size() > 1 ? pulses[1] : -1, 32'd8);
        chk("frame_beat_cnt", {16'd0, bc}, 32'd1);
        do_reset();
        ao = 1'b0;
        d1 = 32'd50; d2 = 32'd50; v1 = 1'b1; v2 = 1'b1;
        tick(8);
        chk("full_ack1", {31'd0, a1}, 32'd0);
        chk("full_ack2", {31'd0, a2}, 32'd0);
        chk("full_vld", {31'd0, vo}, 32'd1);
        reset = 1'b1;
        v1 = 1'b0; v2 = 1'b0;
        tick();
        chk("midrst_vld", {31'd0, vo}, 32'd0);
        chk("midrst_beat_cnt", {16'd0, bc}, 32'd0);
        chk("midrst_data", dout, 32'd0);
        reset = 1'b0;
        got.delete();
        tick();
        ao = 1'b1;
        fork
            send1(32'd3);
            send2(32'd4);
        join
        wait_got(1);
        tick(3);
        chk("post_midrst_count", got.size(), 32'd1);
        chk("post_midrst_sum", at(0), 32'd7);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
